// File: rtl/mdu_unit_pkg.sv
// Shared encodings and defaults for the E-stage multiply/divide unit.
package mdu_unit_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    MDOP_NONE  = 4'd0,
    MDOP_MULT  = 4'd1,
    MDOP_MULTU = 4'd2,
    MDOP_DIV   = 4'd3,
    MDOP_DIVU  = 4'd4,
    MDOP_MTHI  = 4'd5,
    MDOP_MTLO  = 4'd6,
    MDOP_MFHI  = 4'd7,
    MDOP_MFLO  = 4'd8
  } mdop_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // HI/LO pair as produced by one multiply or divide.
  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

endpackage

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO architectural registers.
// The result is computed on the start edge and committed after a fixed latency.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] E_MDU_src1,
  input  logic [XLEN-1:0] E_MDU_src2,
  input  logic [3:0]      MDU_mdOp,
  input  logic            MDU_start,
  output logic            E_MDU_busy,
  output logic [XLEN-1:0] E_MDU_result
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hilo_t           pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;

  logic            is_mul, is_div;
  hilo_t           calc;
  logic            calc_vld;
  logic [2*XLEN-1:0] mul_s, mul_u;
  logic [XLEN-1:0] q_s, r_s, q_u, r_u;
  logic            div_zero, div_ovf;

  // Operation decode.
  always_comb begin
    is_mul = (MDU_mdOp == MDOP_MULT) || (MDU_mdOp == MDOP_MULTU);
    is_div = (MDU_mdOp == MDOP_DIV)  || (MDU_mdOp == MDOP_DIVU);
  end

  // Full-width arithmetic on the current operands; div guards avoid 0 and INT_MIN/-1 traps.
  always_comb begin
    mul_s    = {{XLEN{E_MDU_src1[XLEN-1]}}, E_MDU_src1} * {{XLEN{E_MDU_src2[XLEN-1]}}, E_MDU_src2};
    mul_u    = {{XLEN{1'b0}}, E_MDU_src1} * {{XLEN{1'b0}}, E_MDU_src2};
    div_zero = (E_MDU_src2 == '0);
    div_ovf  = (E_MDU_src1 == 32'h8000_0000) && (E_MDU_src2 == 32'hFFFF_FFFF);
    q_s      = '0;
    r_s      = '0;
    q_u      = '0;
    r_u      = '0;
    if (!div_zero) begin
      q_u = E_MDU_src1 / E_MDU_src2;
      r_u = E_MDU_src1 % E_MDU_src2;
      if (div_ovf) begin
        q_s = 32'h8000_0000;
        r_s = '0;
      end else begin
        q_s = XLEN'($signed(E_MDU_src1) / $signed(E_MDU_src2));
        r_s = XLEN'($signed(E_MDU_src1) % $signed(E_MDU_src2));
      end
    end
    calc     = '0;
    calc_vld = 1'b1;
    case (MDU_mdOp)
      MDOP_MULT:  calc = mul_s;
      MDOP_MULTU: calc = mul_u;
      MDOP_DIV: begin
        calc.hi  = r_s;
        calc.lo  = q_s;
        calc_vld = !div_zero;
      end
      MDOP_DIVU: begin
        calc.hi  = r_u;
        calc.lo  = q_u;
        calc_vld = !div_zero;
      end
      default: calc_vld = 1'b0;
    endcase
  end

  // Next-state: launch, count down, commit pending result; mthi/mtlo when idle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (MDU_start && (is_mul || is_div)) begin
          state_d    = ST_RUN;
          cnt_d      = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          pend_d     = calc;
          pend_vld_d = calc_vld;
        end else if (MDU_mdOp == MDOP_MTHI) begin
          hi_d = E_MDU_src1;
        end else if (MDU_mdOp == MDOP_MTLO) begin
          lo_d = E_MDU_src1;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = ST_IDLE;
          pend_vld_d = 1'b0;
          if (pend_vld_q) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and architectural registers; synchronous reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  // Busy is a direct decode of the registered state.
  assign E_MDU_busy = (state_q == ST_RUN);

  // mfhi/mflo read port follows HI/LO combinationally.
  assign E_MDU_result = (MDU_mdOp == MDOP_MFHI) ? hi_q :
                        (MDU_mdOp == MDOP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] src1, src2;
  logic [3:0]  mdop;
  logic        start;
  logic        busy;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .E_MDU_src1   (src1),
    .E_MDU_src2   (src2),
    .MDU_mdOp     (mdop),
    .MDU_start    (start),
    .E_MDU_busy   (busy),
    .E_MDU_result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read HI then LO through the result port (called on a negedge, start low).
  task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    mdop = 4'd7;
    #1 check({tag, "_hi"}, result, exp_hi);
    mdop = 4'd8;
    #1 check({tag, "_lo"}, result, exp_lo);
    mdop = 4'd0;
  endtask

  // Launch an op, verify busy for exactly n cycles, end on negedge of cycle T+n+1.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n);
    mdop  = op;
    src1  = a;
    src2  = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    mdop  = 4'd0;
    src1  = 32'hDEAD_BEEF;
    src2  = 32'h0BAD_F00D;
    for (int i = 1; i <= n; i++) begin
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      @(negedge clk);
    end
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  // Single-cycle mthi/mtlo write.
  task automatic move_to(input logic [3:0] op, input logic [31:0] a);
    mdop = op;
    src1 = a;
    @(posedge clk);
    @(negedge clk);
    mdop = 4'd0;
    check("mt_nobusy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    src1  = '0;
    src2  = '0;
    mdop  = 4'd0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("reset_busy", {31'b0, busy}, 32'd0);
    check_hilo("reset", 32'h0, 32'h0);
    #1 check("none_read", result, 32'h0);

    run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 5);
    check_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
    check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    check_hilo("div_ovf", 32'h0, 32'h8000_0000);

    move_to(4'd5, 32'h11);
    move_to(4'd6, 32'h22);
    check_hilo("mt", 32'h11, 32'h22);
    run_op("divu0", 4'd4, 32'd7, 32'd0, 10);
    check_hilo("divu0", 32'h11, 32'h22);

    run_op("divu", 4'd4, 32'hFFFF_FFFF, 32'h10, 10);
    check_hilo("divu", 32'h0000_000F, 32'h0FFF_FFFF);

    run_op("div_neg", 4'd3, 32'd7, 32'hFFFF_FFFE, 10);
    check_hilo("div_neg", 32'h0000_0001, 32'hFFFF_FFFD);

    // start with a non-arithmetic code must not launch
    mdop  = 4'd9;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    mdop  = 4'd0;
    check("bad_op_busy", {31'b0, busy}, 32'd0);
    check_hilo("bad_op", 32'h0000_0001, 32'hFFFF_FFFD);

    // reset in the 4th busy cycle aborts the divide
    mdop  = 4'd3;
    src1  = 32'd100;
    src2  = 32'd7;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    mdop  = 4'd0;
    check("abort_busy1", {31'b0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    check("abort_busy4", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_idle", {31'b0, busy}, 32'd0);
    check_hilo("abort", 32'h0, 32'h0);
    reset = 1'b0;
    repeat (12) begin
      @(negedge clk);
      n_cmp++;
      assert (busy === 1'b0) else begin
        n_err++;
        $error("FAIL abort_stay_idle observed=%b expected=0", busy);
      end
    end
    check_hilo("abort_late", 32'h0, 32'h0);

    move_to(4'd6, 32'h0000_ABCD);
    check_hilo("mtlo", 32'h0, 32'h0000_ABCD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
